// File: rtl/jt49_period_meas_pkg.sv
// Shared types for the period meter: FSM state encoding.
package jt49_period_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } meas_state_t;

endpackage

// File: rtl/jt49_period_meas.sv
// Measures the half-period of a square wave in cen ticks, reporting the divider
// period that would reproduce it, plus lock (steady tone) and stall flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no reference edge yet (after reset or after a stall)
//   ARMED | one edge seen; the next edge yields the first capture
//   RUN   | capturing every edge; lock compares against previous capture
module jt49_period_meas
   import jt49_period_meas_pkg::*;
#(
   parameter int width = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             sq,
   output logic [width-1:0] period,
   output logic             valid,
   output logic             locked,
   output logic             stalled
);

   localparam logic [width-1:0] ONE = width'(1);
   localparam logic [width-1:0] MAX = {width{1'b1}};

   meas_state_t      state, state_nx;
   logic             sq_l;
   logic [width-1:0] cnt;
   logic             sq_edge;
   logic             capture;
   logic             stall;

   assign sq_edge = cen & (sq ^ sq_l);

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      stall    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sq_edge) state_nx = ST_ARMED;
         end
         ST_ARMED, ST_RUN: begin
            // an edge landing exactly on the timeout still counts as a capture
            if (sq_edge) begin
               state_nx = ST_RUN;
               capture  = 1'b1;
            end else if (cen && cnt == MAX) begin
               state_nx = ST_IDLE;
               stall    = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         sq_l    <= 1'b0;
         cnt     <= ONE;
         period  <= '0;
         valid   <= 1'b0;
         locked  <= 1'b0;
         stalled <= 1'b0;
      end else begin
         state <= state_nx;
         valid <= capture | stall;
         if (cen) begin
            sq_l <= sq;
            if (sq_edge)
               cnt <= ONE;
            else if (cnt != MAX)
               cnt <= cnt + ONE;
         end
         if (capture) begin
            period <= cnt;
            locked <= (state == ST_RUN) && (cnt == period);
            if (state == ST_ARMED) stalled <= 1'b0;
         end
         if (stall) begin
            period  <= '0;
            locked  <= 1'b0;
            stalled <= 1'b1;
         end
      end
   end

endmodule
